// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS single-RAM instruction/data memory path.
package mips_mem_pkg;

    localparam int MEM_ADDR_W     = 5;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_STARVE_MAX = 3;

    // Which port owns the RAM read data arriving in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_grant_logic.sv
// Fixed DM-over-IF priority with a bounded starvation counter that forces an IF grant.
module mem_grant_logic
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = MEM_STARVE_MAX
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve;
    logic       w_if_first;

    assign w_if_first = (r_starve == LP_STARVE_MAX);

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (reset_n) begin
            if (dm_req && !(if_req && w_if_first)) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Counts consecutive cycles in which DM took the RAM while IF was waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= 4'd0;
        end else if (if_gnt || !if_req) begin
            r_starve <= 4'd0;
        end else if (dm_gnt && (r_starve != LP_STARVE_MAX)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous RAM between instruction fetch and data memory, one access
// per cycle, routing the 1-cycle-latency read data back to whichever port issued it.
module imem_dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = MEM_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_stall,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Handshake: a port holds req (and its address/data) until it sees gnt in the
    // same cycle; a granted read returns with valid exactly one cycle later, and a
    // requester that is not granted sees stall, which freezes the PC or MEM stage.
    logic   w_if_gnt;
    logic   w_dm_gnt;
    owner_t w_owner_d;
    owner_t r_owner;
    logic   r_if_kill;
    logic [DATA_W-1:0] r_if_hold;
    logic [DATA_W-1:0] r_dm_hold;

    mem_grant_logic #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .if_gnt  (w_if_gnt),
        .dm_gnt  (w_dm_gnt)
    );

    assign if_gnt   = w_if_gnt;
    assign dm_gnt   = w_dm_gnt;
    assign if_stall = if_req & ~w_if_gnt;
    assign dm_stall = dm_req & ~w_dm_gnt;

    always_comb begin
        ram_addr  = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_din   = '0;
        w_owner_d = OWN_NONE;
        if (w_if_gnt) begin
            ram_addr  = if_addr;
            ram_re    = 1'b1;
            w_owner_d = OWN_IF;
        end else if (w_dm_gnt) begin
            ram_addr = dm_addr;
            if (dm_we) begin
                ram_we  = 1'b1;
                ram_din = dm_wdata;
            end else begin
                ram_re    = 1'b1;
                w_owner_d = OWN_DM;
            end
        end
    end

    // A fetch flushed in its grant cycle still reads the RAM but is never delivered.
    assign if_valid = reset_n && (r_owner == OWN_IF) && !r_if_kill;
    assign dm_valid = reset_n && (r_owner == OWN_DM);
    assign if_rdata = if_valid ? ram_dout : r_if_hold;
    assign dm_rdata = dm_valid ? ram_dout : r_dm_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner   <= OWN_NONE;
            r_if_kill <= 1'b0;
            r_if_hold <= '0;
            r_dm_hold <= '0;
        end else begin
            r_owner   <= w_owner_d;
            r_if_kill <= w_if_gnt & if_flush;
            if (if_valid) begin
                r_if_hold <= ram_dout;
            end
            if (dm_valid) begin
                r_dm_hold <= ram_dout;
            end
        end
    end

endmodule
